// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Generates the
//   PC, keeps at most one instruction-memory request in flight, and presents
//   the fetched instruction with its PC to decode. A decode redirect squashes
//   the wrong-path fetch. A decode hazard holds IF/ID, and a one-entry skid
//   buffer catches the response that was already in flight.
//
// Parameters
//   RESET_PC       first fetch address after reset
//   NOP_INSTR      value shown on ifid_instr while ifid_valid is low
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   branch_taken   redirect request from decode
//   branch_target  redirect PC (bits [1:0] ignored)
//   hazard         decode stall, IF/ID must hold
//   imem_req       fetch request
//   imem_addr      fetch address, word aligned
//   imem_gnt       request accepted this cycle
//   imem_rvalid    read data valid
//   imem_rdata     instruction word
//   ifid_valid     IF/ID holds a valid instruction
//   ifid_pc        PC of ifid_instr
//   ifid_instr     instruction to decode (NOP_INSTR when not valid)
//   perf_fetch_cnt IF/ID loads       (only with FETCH_PERF_CNT_EN)
//   perf_flush_cnt redirect cycles   (only with FETCH_PERF_CNT_EN)
//
// Configuration macro
//   FETCH_PERF_CNT_EN  adds the two 32-bit performance counters and their ports
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        hazard,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] resp_pc;
   logic [31:0] ifid_instr_q;
   logic        skid_valid;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;
   logic        req_accept;
   logic        deliver;
   logic        ifid_open;
   logic        ifid_load;
   logic        skid_write;
   logic        skid_drain;
   logic        unused_target_lsbs;

   // The two low target bits are dropped on purpose, because fetches are always word aligned.
   assign unused_target_lsbs = ^branch_target[1:0];

   // The PC advances as soon as a request is granted. While a response is
   // outstanding in S_WAIT, the returning word therefore belongs to pc-4.
   // A redirect always leaves S_WAIT, so this relation cannot go stale.
   assign req_accept = imem_req && imem_gnt;
   assign resp_pc    = pc - 32'd4;
   assign deliver    = (state == S_WAIT) && imem_rvalid && !branch_taken;

   // IF/ID can take a new word when it is empty or decode is consuming it.
   // The skid entry is always older than a same-cycle delivery, so it goes first.
   // A delivery that cannot go straight into IF/ID lands in the skid entry.
   // The skid cannot overflow because no new request is issued while it is full.
   assign ifid_open  = !ifid_valid || !hazard;
   assign ifid_load  = ifid_open && (skid_valid || deliver) && !branch_taken;
   assign skid_write = deliver && (skid_valid || !ifid_open);
   assign skid_drain = ifid_open && skid_valid;

   // The state register is the only place the FSM state is stored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_REQ;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A redirect turns any request already in flight into a
   // drop, so its data is discarded when it returns. A redirect that arrives in
   // S_DROP together with the awaited rvalid still returns to S_REQ; otherwise
   // the stage would wait forever for a response that is never coming.
   always_comb begin
      state_next = state;
      case (state)
         S_REQ: begin
            if (req_accept) begin
               state_next = branch_taken ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_next = S_REQ;
            end else if (branch_taken) begin
               state_next = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rvalid) begin
               state_next = S_REQ;
            end
         end
         default: state_next = S_REQ;
      endcase
   end

   // Outputs decoded from state. Requests pause while the skid entry is
   // occupied. The IF/ID word is replaced by a NOP whenever it is not valid.
   always_comb begin
      imem_req   = (state == S_REQ) && !skid_valid;
      imem_addr  = pc;
      ifid_instr = ifid_valid ? ifid_instr_q : NOP_INSTR;
   end

   // Program counter. A redirect overrides the normal +4 advance. The addition
   // wraps naturally at the top of the address space.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= {RESET_PC[31:2], 2'b00};
      end else if (branch_taken) begin
         pc <= {branch_target[31:2], 2'b00};
      end else if (req_accept) begin
         pc <= pc + 32'd4;
      end
   end

   // IF/ID register and skid entry. A redirect empties both and also discards
   // any delivery in the same cycle. Otherwise IF/ID is refilled from the skid
   // entry or from memory, and it empties when decode consumes with nothing
   // left behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_valid   <= 1'b0;
         ifid_pc      <= 32'd0;
         ifid_instr_q <= NOP_INSTR;
         skid_valid   <= 1'b0;
         skid_pc      <= 32'd0;
         skid_instr   <= 32'd0;
      end else if (branch_taken) begin
         ifid_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (ifid_open) begin
            ifid_valid <= ifid_load;
         end
         if (ifid_load) begin
            ifid_pc      <= skid_valid ? skid_pc : resp_pc;
            ifid_instr_q <= skid_valid ? skid_instr : imem_rdata;
         end
         if (skid_write) begin
            skid_valid <= 1'b1;
            skid_pc    <= resp_pc;
            skid_instr <= imem_rdata;
         end else if (skid_drain) begin
            skid_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Performance counters. One counts every IF/ID load, whether it comes from
   // memory or from the skid entry. The other counts every redirect cycle.
   // Both wrap at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         if (ifid_load) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (branch_taken) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A behavioural memory returns
//   instr = addr + 0xA0 after a random or fixed latency. The program-order
//   model only tracks the next PC that decode should see. It advances by 4 on
//   each consumed instruction and jumps to the aligned target on a redirect.
//   Inputs change on the falling edge, and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        hazard;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   logic        mem_pending;
   logic [31:0] mem_addr;
   int unsigned mem_wait;
   int unsigned gnt_pct;
   int unsigned lat_min;
   int unsigned lat_max;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .hazard        (hazard),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .ifid_valid    (ifid_valid),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a + 32'h0000_00A0;
   endfunction

   // Memory model, called once per falling edge. It decides gnt/rvalid for the
   // next rising edge and holds at most one outstanding response.
   task automatic mem_step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
      if (mem_pending) begin
         if (mem_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_addr);
            mem_pending = 1'b0;
         end else begin
            mem_wait = mem_wait - 1;
         end
      end else if (imem_req && ($urandom_range(99) < gnt_pct)) begin
         imem_gnt    = 1'b1;
         mem_pending = 1'b1;
         mem_addr    = imem_addr;
         mem_wait    = $urandom_range(lat_max, lat_min);
      end
   endtask

   // Holds reset across one or more rising edges, then releases it on a
   // falling edge. The DUT is left showing its post-reset state.
   task automatic do_reset();
      reset         = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'd0;
      hazard        = 1'b0;
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      imem_rdata    = 32'd0;
      mem_pending   = 1'b0;
      mem_wait      = 0;
      gnt_pct       = 100;
      lat_min       = 0;
      lat_max       = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_compared++;
      if (imem_req !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL reset_req: got %0b want 1", imem_req);
      end
      n_compared++;
      if (imem_addr !== 32'h0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_addr: got %h want 00000000", imem_addr);
      end
      n_compared++;
      if (ifid_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_valid: got %0b want 0", ifid_valid);
      end
      n_compared++;
      if (ifid_instr !== NOP) begin
         n_mismatched++;
         $display("[TB] FAIL reset_instr: got %h want %h", ifid_instr, NOP);
      end
      n_compared++;
      if (ifid_pc !== 32'h0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_pc: got %h want 00000000", ifid_pc);
      end
   endtask

   task automatic test_zero_wait();
      logic        exp_v;
      logic [31:0] exp_pc;
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         exp_v  = (c >= 2) && (c % 2 == 0);
         exp_pc = 32'((c / 2 - 1) * 4);
         n_compared++;
         if (ifid_valid !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL zw_valid c%0d: got %0b want %0b", c, ifid_valid, exp_v);
         end
         if (exp_v) begin
            n_compared++;
            if (ifid_pc !== exp_pc || ifid_instr !== instr_of(exp_pc)) begin
               n_mismatched++;
               $display("[TB] FAIL zw_data c%0d: got (%h,%h) want (%h,%h)",
                        c, ifid_pc, ifid_instr, exp_pc, instr_of(exp_pc));
            end
         end
         mem_step();
         @(negedge clk);
      end
   endtask

   task automatic test_redirect();
      logic found;
      do_reset();
      lat_min = 1;
      lat_max = 1;
      found   = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (imem_req && imem_addr == 32'h8) begin
            found = 1'b1;
            break;
         end
         mem_step();
         @(negedge clk);
      end
      n_compared++;
      if (!found) begin
         n_mismatched++;
         $display("[TB] FAIL redir_reach8: got no request for 8 want request within 40 cycles");
      end
      mem_step();
      @(negedge clk);
      branch_taken  = 1'b1;
      branch_target = 32'h100;
      mem_step();
      @(negedge clk);
      branch_taken = 1'b0;
      n_compared++;
      if (ifid_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL redir_squash: got valid=%0b req=%0b want 0 0", ifid_valid, imem_req);
      end
      mem_step();
      @(negedge clk);
      n_compared++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         n_mismatched++;
         $display("[TB] FAIL redir_addr: got req=%0b addr=%h want 1 00000100", imem_req, imem_addr);
      end
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (ifid_valid) begin
            found = 1'b1;
            break;
         end
         mem_step();
         @(negedge clk);
      end
      n_compared++;
      if (!found || ifid_pc !== 32'h100 || ifid_instr !== 32'h1A0) begin
         n_mismatched++;
         $display("[TB] FAIL redir_first: got v=%0b (%h,%h) want (00000100,000001a0)",
                  found, ifid_pc, ifid_instr);
      end
      gnt_pct       = 0;
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h203;
      @(negedge clk);
      branch_taken = 1'b0;
      n_compared++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200 || ifid_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL redir_nogrant: got req=%0b addr=%h v=%0b want 1 00000200 0",
                  imem_req, imem_addr, ifid_valid);
      end
   endtask

   task automatic test_hazard();
      logic        found;
      logic [31:0] seen[$];
      do_reset();
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (ifid_valid && ifid_pc == 32'h4) begin
            found = 1'b1;
            break;
         end
         mem_step();
         @(negedge clk);
      end
      n_compared++;
      if (!found) begin
         n_mismatched++;
         $display("[TB] FAIL haz_reach4: got no ifid_pc 4 want within 20 cycles");
      end
      for (int h = 0; h < 4; h++) begin
         hazard = 1'b1;
         n_compared++;
         if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || ifid_instr !== 32'hA4) begin
            n_mismatched++;
            $display("[TB] FAIL haz_hold h%0d: got v=%0b (%h,%h) want 1 (4,a4)",
                     h, ifid_valid, ifid_pc, ifid_instr);
         end
         if (h >= 2) begin
            n_compared++;
            if (imem_req !== 1'b0) begin
               n_mismatched++;
               $display("[TB] FAIL haz_noreq h%0d: got %0b want 0", h, imem_req);
            end
         end
         mem_step();
         @(negedge clk);
      end
      hazard = 1'b0;
      for (int k = 0; k < 20 && seen.size() < 3; k++) begin
         if (ifid_valid) begin
            seen.push_back(ifid_pc);
         end
         mem_step();
         @(negedge clk);
      end
      n_compared++;
      if (seen.size() != 3 || seen[0] !== 32'h4 || seen[1] !== 32'h8 || seen[2] !== 32'hC) begin
         n_mismatched++;
         $display("[TB] FAIL haz_release: got %0d entries %p want 4,8,c", seen.size(), seen);
      end
   endtask

   task automatic test_reset_midflight();
      logic found;
      do_reset();
      lat_min = 1;
      lat_max = 1;
      mem_step();
      @(negedge clk);
      reset = 1'b1;
      mem_step();
      @(negedge clk);
      reset = 1'b0;
      n_compared++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL rstmid_state: got req=%0b addr=%h v=%0b want 1 00000000 0",
                  imem_req, imem_addr, ifid_valid);
      end
      mem_step();
      @(negedge clk);
      n_compared++;
      if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_mismatched++;
         $display("[TB] FAIL rstmid_ignored: got v=%0b req=%0b addr=%h want 0 1 00000000",
                  ifid_valid, imem_req, imem_addr);
      end
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (ifid_valid) begin
            found = 1'b1;
            break;
         end
         mem_step();
         @(negedge clk);
      end
      n_compared++;
      if (!found || ifid_pc !== 32'h0 || ifid_instr !== 32'hA0) begin
         n_mismatched++;
         $display("[TB] FAIL rstmid_refetch: got v=%0b (%h,%h) want (0,a0)", found, ifid_pc, ifid_instr);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] seen[$];
      do_reset();
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFF;
      mem_step();
      @(negedge clk);
      branch_taken = 1'b0;
      n_compared++;
      if (imem_req !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL wrap_drop: got req=%0b want 0", imem_req);
      end
      mem_step();
      @(negedge clk);
      n_compared++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         n_mismatched++;
         $display("[TB] FAIL wrap_addr: got req=%0b addr=%h want 1 fffffffc", imem_req, imem_addr);
      end
      for (int k = 0; k < 20 && seen.size() < 2; k++) begin
         if (ifid_valid) begin
            seen.push_back(ifid_pc);
            n_compared++;
            if (ifid_instr !== instr_of(ifid_pc)) begin
               n_mismatched++;
               $display("[TB] FAIL wrap_instr: got %h want %h", ifid_instr, instr_of(ifid_pc));
            end
         end
         mem_step();
         @(negedge clk);
      end
      n_compared++;
      if (seen.size() != 2 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
         n_mismatched++;
         $display("[TB] FAIL wrap_seq: got %0d entries %p want fffffffc,0", seen.size(), seen);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_next;
      logic [31:0] prev_addr;
      logic        prev_hold;
      logic        prev_branch;
      int          consumed;
      do_reset();
      gnt_pct     = 60;
      lat_min     = 0;
      lat_max     = 3;
      exp_next    = 32'h0;
      prev_hold   = 1'b0;
      prev_branch = 1'b0;
      prev_addr   = 32'h0;
      consumed    = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         n_compared++;
         if (ifid_valid) begin
            if (ifid_pc !== exp_next || ifid_instr !== instr_of(exp_next)) begin
               n_mismatched++;
               $display("[TB] FAIL rnd_order cyc%0d: got (%h,%h) want (%h,%h)",
                        cyc, ifid_pc, ifid_instr, exp_next, instr_of(exp_next));
            end
         end else if (ifid_instr !== NOP) begin
            n_mismatched++;
            $display("[TB] FAIL rnd_nop cyc%0d: got %h want %h", cyc, ifid_instr, NOP);
         end
         if (prev_branch) begin
            n_compared++;
            if (ifid_valid !== 1'b0) begin
               n_mismatched++;
               $display("[TB] FAIL rnd_flush cyc%0d: got valid=%0b want 0", cyc, ifid_valid);
            end
         end
         n_compared++;
         if (imem_addr[1:0] !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL rnd_align cyc%0d: got addr=%h want low bits 00", cyc, imem_addr);
         end
         if (prev_hold) begin
            n_compared++;
            if (imem_addr !== prev_addr) begin
               n_mismatched++;
               $display("[TB] FAIL rnd_stable cyc%0d: got addr=%h want %h", cyc, imem_addr, prev_addr);
            end
         end
         mem_step();
         hazard        = ($urandom_range(99) < 30);
         branch_taken  = !hazard && ($urandom_range(99) < 4);
         branch_target = $urandom();
         if (branch_taken) begin
            exp_next = {branch_target[31:2], 2'b00};
         end else if (ifid_valid && !hazard) begin
            exp_next = exp_next + 32'd4;
            consumed++;
         end
         prev_hold   = imem_req && !imem_gnt && !branch_taken;
         prev_addr   = imem_addr;
         prev_branch = branch_taken;
         @(negedge clk);
      end
      branch_taken = 1'b0;
      hazard       = 1'b0;
      n_compared++;
      if (consumed < 100) begin
         n_mismatched++;
         $display("[TB] FAIL rnd_progress: got %0d consumed want >= 100", consumed);
      end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf();
      int loads;
      do_reset();
      loads = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (ifid_valid) begin
            loads++;
         end
         if (loads == 10) begin
            break;
         end
         mem_step();
         branch_taken  = (cyc == 7) || (cyc == 15);
         branch_target = (cyc == 7) ? 32'h400 : 32'h800;
         @(negedge clk);
      end
      branch_taken = 1'b0;
      n_compared++;
      if (loads != 10 || perf_fetch_cnt !== 32'd10) begin
         n_mismatched++;
         $display("[TB] FAIL perf_fetch: got %0d (seen %0d) want 10", perf_fetch_cnt, loads);
      end
      n_compared++;
      if (perf_flush_cnt !== 32'd2) begin
         n_mismatched++;
         $display("[TB] FAIL perf_flush: got %0d want 2", perf_flush_cnt);
      end
   endtask
`endif

   // Test sequence. Each test starts from a fresh reset.
   initial begin
      test_reset();
      test_zero_wait();
      test_redirect();
      test_hazard();
      test_reset_midflight();
      test_wrap();
      test_random();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
